// File: rtl/iob_2p_assim_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// iob_2p_assim_fifo_ctrl_if
// Bundle of every non-clock signal of the asymmetric FIFO controller: the
// user push/pop side and the external asymmetric 2-port RAM port.
//   slave  : controller view (drives status, read data and RAM controls)
//   master : user + RAM view (drives push/pop/w_data and mem_r_data)
// Signals:
//   push, w_data      push request, one wide word
//   pop               pop request, one narrow word
//   r_data, r_valid   popped narrow word and its valid strobe
//   full, empty       status flags
//   level             occupancy in narrow (read) words
//   overflow          one-cycle pulse after a push refused because full
//   underflow         one-cycle pulse after a pop refused because empty
//   mem_w_*           RAM write port (wide words)
//   mem_r_*           RAM read port (narrow words, 1-cycle latency)
// ---------------------------------------------------------------------------
interface iob_2p_assim_fifo_ctrl_if #(
    parameter int W_DATA_W = 16,
    parameter int R_DATA_W = 8,
    parameter int W_ADDR_W = 6,
    parameter int R_ADDR_W = 7
);
    logic                push;
    logic [W_DATA_W-1:0] w_data;
    logic                pop;
    logic [R_DATA_W-1:0] r_data;
    logic                r_valid;
    logic                full;
    logic                empty;
    logic [R_ADDR_W:0]   level;
    logic                overflow;
    logic                underflow;

    logic                mem_w_en;
    logic [W_ADDR_W-1:0] mem_w_addr;
    logic [W_DATA_W-1:0] mem_w_data;
    logic                mem_r_en;
    logic [R_ADDR_W-1:0] mem_r_addr;
    logic [R_DATA_W-1:0] mem_r_data;

    modport slave (
        input  push, w_data, pop, mem_r_data,
        output r_data, r_valid, full, empty, level, overflow, underflow,
        output mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
    );

    modport master (
        output push, w_data, pop, mem_r_data,
        input  r_data, r_valid, full, empty, level, overflow, underflow,
        input  mem_w_en, mem_w_addr, mem_w_data, mem_r_en, mem_r_addr
    );
endinterface

// File: rtl/iob_2p_assim_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// iob_2p_assim_fifo_ctrl
// Controller for a FIFO whose push side writes wide words (W_DATA_W) and
// whose pop side reads narrow words (R_DATA_W = W_DATA_W / RATIO) from an
// external asymmetric 2-port RAM with a 1-cycle read latency.
// Ports:
//   clk   clock (both RAM ports run on it as well)
//   rst   asynchronous active-high reset
//   bus   iob_2p_assim_fifo_ctrl_if.slave (user side + RAM port)
// Narrow-word ordering: the RAM maps read address {wide_addr, k} to slice k
// of the wide word, so popping sequential read addresses yields slice 0
// first, then slice 1, and so on.
// ---------------------------------------------------------------------------
module iob_2p_assim_fifo_ctrl #(
    parameter int W_DATA_W = 16,
    parameter int R_DATA_W = 8,
    parameter int W_ADDR_W = 6,
    parameter int R_ADDR_W = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    iob_2p_assim_fifo_ctrl_if.slave      bus
);
    localparam int RATIO   = W_DATA_W / R_DATA_W;
    localparam int DEPTH_I = 1 << R_ADDR_W;

    // Level is counted in narrow words; a push needs room for RATIO of them.
    localparam logic [R_ADDR_W:0] L_FULL_TH = (R_ADDR_W+1)'(DEPTH_I - RATIO);
    localparam logic [R_ADDR_W:0] L_RATIO   = (R_ADDR_W+1)'(RATIO);

    logic [W_ADDR_W-1:0] r_wptr;
    logic [R_ADDR_W-1:0] r_rptr;
    logic [R_ADDR_W:0]   r_level;
    logic                r_r_valid;
    logic                r_overflow;
    logic                r_underflow;

    logic                w_full;
    logic                w_empty;
    logic                w_push_ok;
    logic                w_pop_ok;
    logic [R_ADDR_W:0]   w_level_next;

    // Status comes straight from the level register, so both requests in a
    // cycle are judged against the occupancy at the start of that cycle.
    assign w_full  = (r_level > L_FULL_TH);
    assign w_empty = (r_level == '0);

    // rst gating keeps the RAM enables low for the whole reset window, not
    // only from the next clock edge.
    assign w_push_ok = bus.push & ~w_full  & ~rst;
    assign w_pop_ok  = bus.pop  & ~w_empty & ~rst;

    always_comb begin
        w_level_next = r_level;
        if (w_push_ok) begin
            w_level_next = w_level_next + L_RATIO;
        end
        if (w_pop_ok) begin
            w_level_next = w_level_next - 1'b1;
        end
    end

    // Pointers wrap naturally at their width; the RAM depth matches it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_r_valid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_level     <= w_level_next;
            r_r_valid   <= w_pop_ok;
            r_overflow  <= bus.push & w_full;
            r_underflow <= bus.pop  & w_empty;
        end
    end

    // RAM port: addresses and write data are always presented; only the
    // enables qualify them. There is no bypass: data written this cycle is
    // never the target of a read this cycle because a pop needs the word to
    // be already counted in the level.
    assign bus.mem_w_en   = w_push_ok;
    assign bus.mem_w_addr = r_wptr;
    assign bus.mem_w_data = bus.w_data;
    assign bus.mem_r_en   = w_pop_ok;
    assign bus.mem_r_addr = r_rptr;

    assign bus.r_data    = bus.mem_r_data;
    assign bus.r_valid   = r_r_valid;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule
